// File: rtl/snn_noc_pkg.sv
// Shared definitions for the SNN NoC spike path: default sizes and dispatcher states.
package snn_noc_pkg;

  localparam int SNN_NUM_NEURONS = 10;
  localparam int SNN_ADDR_BITS   = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } disp_state_t;

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest set bit and an any-set flag.
module spike_prio_enc
  import snn_noc_pkg::*;
#(
  parameter int WIDTH = SNN_NUM_NEURONS,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scanning from the top down lets the lowest set bit win the final assignment.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// Serialises a latched fired-neuron vector into one source address per transfer, lowest index first.
// Optional drop counter enabled by defining SPIKE_DROP_COUNT_EN.
module spike_dispatcher
  import snn_noc_pkg::*;
#(
  parameter int NUM_NEURONS = SNN_NUM_NEURONS,
  parameter int ADDR_BITS   = SNN_ADDR_BITS
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NUM_NEURONS-1:0] spikes_in,
  input  logic                   spikes_valid,
  input  logic [ADDR_BITS-1:0]   base_address,
  output logic [ADDR_BITS-1:0]   source_address,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   clear,
  output logic [7:0]             drop_count
);

  localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  disp_state_t            state_q, state_d;
  logic [NUM_NEURONS-1:0] pending_q, pending_d;
  logic [NUM_NEURONS-1:0] pending_clr;
  logic [IDX_W-1:0]       enc_idx;
  logic                   enc_any;
  logic                   xfer;

  spike_prio_enc #(
    .WIDTH (NUM_NEURONS),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .vec (pending_q),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Outputs decode straight from registered state so they stay put until a transfer.
  assign out_valid      = (state_q == SEND) & enc_any;
  assign xfer           = out_valid & out_ready;
  assign source_address = out_valid ? (base_address + ADDR_BITS'(enc_idx)) : '0;
  assign busy           = (state_q != IDLE);
  assign clear          = (state_q == DONE);
  assign pending_clr    = pending_q & ~(NUM_NEURONS'(1) << enc_idx);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (spikes_valid) begin
          pending_d = spikes_in;
          state_d   = (|spikes_in) ? SEND : DONE;
        end
      end
      SEND: begin
        if (xfer) begin
          pending_d = pending_clr;
          if (pending_clr == '0) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

`ifdef SPIKE_DROP_COUNT_EN
  logic [7:0] drop_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Any timestep arriving while a previous vector is in flight (SEND or DONE) is lost.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      drop_cnt_q <= 8'd0;
    end else if (spikes_valid && (state_q != IDLE)) begin
      drop_cnt_q <= sat_inc8(drop_cnt_q);
    end
  end

  assign drop_count = drop_cnt_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// Scoreboard bench for spike_dispatcher: directed vectors push expected events, a negedge monitor checks them.
module tb_spike_dispatcher;

  logic        CLK;
  logic        RESET;
  logic [9:0]  spikes_in;
  logic        spikes_valid;
  logic [11:0] base_address;
  logic [11:0] source_address;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        clear;
  logic [7:0]  drop_count;

  typedef struct packed {
    bit          is_clr;
    logic [11:0] addr;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks;
  int   n_fail;
  bit   stall_seen;
  logic [11:0] stall_addr;

  spike_dispatcher #(
    .NUM_NEURONS (10),
    .ADDR_BITS   (12)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .spikes_in      (spikes_in),
    .spikes_valid   (spikes_valid),
    .base_address   (base_address),
    .source_address (source_address),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .clear          (clear),
    .drop_count     (drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_addr(input logic [11:0] a);
    ev_t e;
    e.is_clr = 1'b0;
    e.addr   = a;
    exp_q.push_back(e);
  endtask

  task automatic push_clr();
    ev_t e;
    e.is_clr = 1'b1;
    e.addr   = 12'h000;
    exp_q.push_back(e);
  endtask

  // Leaves the caller just after the edge that sampled the vector.
  task automatic pulse(input logic [9:0] v);
    @(posedge CLK); #1;
    spikes_in    = v;
    spikes_valid = 1'b1;
    @(posedge CLK); #1;
    spikes_valid = 1'b0;
    spikes_in    = 10'h000;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic drain(input int max_cycles);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < max_cycles) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("drain_done", exp_q.size(), 0);
    exp_q.delete();
    idle(3);
  endtask

  // Monitor: checks every presented address/clear against the scoreboard and holds under stall.
  always @(negedge CLK) begin
    ev_t e;
    if (RESET) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_addr", source_address, stall_addr);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_addr", source_address, 32'hDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_addr", e.is_clr, 0);
          chk("source_address", source_address, e.addr);
        end
      end
      if (clear) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_clear", clear, 0);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_clear", e.is_clr, 1);
          chk("clear_not_valid", out_valid, 0);
        end
      end
      stall_seen = out_valid && !out_ready;
      stall_addr = source_address;
    end
  end

  initial begin
    logic [7:0] exp_drops;
    n_checks     = 0;
    n_fail       = 0;
    stall_seen   = 1'b0;
    stall_addr   = '0;
    RESET        = 1'b1;
    spikes_in    = 10'h000;
    spikes_valid = 1'b0;
    base_address = 12'h100;
    out_ready    = 1'b1;

    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_addr", source_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clear", clear, 0);
    chk("rst_drop", drop_count, 0);
    idle(2);
    RESET = 1'b0;
    idle(2);

    // Three spikes at full throughput.
    base_address = 12'h100;
    push_addr(12'h100); push_addr(12'h102); push_addr(12'h105); push_clr();
    pulse(10'b0000100101);
    chk("t1_first_valid", out_valid, 1);
    chk("t1_busy", busy, 1);
    drain(20);
    chk("t1_idle_busy", busy, 0);

    // Empty vector: a single clear cycle, no addresses.
    push_clr();
    pulse(10'h000);
    chk("t2_no_valid", out_valid, 0);
    chk("t2_clear", clear, 1);
    chk("t2_busy_done", busy, 1);
    @(posedge CLK); #1;
    chk("t2_clear_gone", clear, 0);
    chk("t2_busy_idle", busy, 0);
    drain(5);

    // Address wrap with a toggling receiver.
    base_address = 12'hFFE;
    out_ready    = 1'b0;
    push_addr(12'hFFE); push_addr(12'hFFF); push_addr(12'h000); push_addr(12'h001); push_clr();
    pulse(10'b0000001111);
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    drain(5);

    // Vectors arriving mid-send are dropped.
    base_address = 12'h200;
    out_ready    = 1'b0;
    push_addr(12'h200); push_addr(12'h201); push_addr(12'h209); push_clr();
    pulse(10'b1000000011);
    for (int i = 0; i < 3; i++) pulse(10'h3FF);
`ifdef SPIKE_DROP_COUNT_EN
    exp_drops = 8'd3;
`else
    exp_drops = 8'd0;
`endif
    chk("t4_drop3", drop_count, exp_drops);
    out_ready = 1'b1;
    drain(20);

    out_ready = 1'b0;
    push_addr(12'h200); push_clr();
    pulse(10'h001);
    for (int i = 0; i < 252; i++) pulse(10'h155);
`ifdef SPIKE_DROP_COUNT_EN
    exp_drops = 8'd255;
`else
    exp_drops = 8'd0;
`endif
    chk("t4_drop255", drop_count, exp_drops);
    for (int i = 0; i < 48; i++) pulse(10'h2AA);
    chk("t4_drop_sat", drop_count, exp_drops);
    out_ready = 1'b1;
    drain(20);

    // Reset after two of five transfers discards the rest.
    base_address = 12'h040;
    out_ready    = 1'b1;
    push_addr(12'h040); push_addr(12'h041);
    pulse(10'b0000011111);
    @(posedge CLK);
    @(posedge CLK); #1;
    chk("t5_third_pending", source_address, 12'h042);
    RESET = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_addr", source_address, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_clear", clear, 0);
    chk("t5_rst_drop", drop_count, 0);
    chk("t5_sb_empty", exp_q.size(), 0);
    idle(2);
    RESET = 1'b0;
    idle(4);
    chk("t5_post_busy", busy, 0);
    push_addr(12'h049); push_clr();
    pulse(10'b1000000000);
    chk("t5_restart_valid", out_valid, 1);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_dispatcher.md
SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, number of local neurons served.
REQ-002 SHALL have parameter ADDR_BITS, default 12, width of one source address.
REQ-003 SHALL have port CLK  input  1  the only clock; all state on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port spikes_in  input  NUM_NEURONS  fired-neuron vector; bit i = neuron i spiked this timestep.
REQ-006 SHALL have port spikes_valid  input  1  one-cycle pulse at timestep end; spikes_in is sampled only when it is high.
REQ-007 SHALL have port base_address  input  ADDR_BITS  address of neuron 0; static during operation.
REQ-008 SHALL have port source_address  output  ADDR_BITS  address of the spike being sent, driven toward MAC/NoC receivers.
REQ-009 SHALL have port out_valid  output  1  source_address holds a valid spike.
REQ-010 SHALL have port out_ready  input  1  the receiver accepts; transfer = out_valid & out_ready on a rising edge.
REQ-011 SHALL have port busy  output  1  a latched vector is still being sent.
REQ-012 SHALL have port clear  output  1  one-cycle timestep-done pulse; matches the receiver clear semantics.
REQ-013 SHALL have port drop_count  output  8  count of timesteps dropped while busy.

Function
REQ-014 SHALL use states IDLE, SEND, DONE.
REQ-015 In IDLE, spikes_valid=1 SHALL latch spikes_in into the pending register; next state SEND if the vector is non-zero, else DONE.
REQ-016 In SEND, out_valid SHALL be 1; source_address = base_address + lowest set pending index, modulo 2^ADDR_BITS (wraps).
REQ-017 out_valid and source_address SHALL hold stable until a transfer occurs; out_valid SHALL never drop without a transfer.
REQ-018 On each transfer, the sent bit SHALL clear; the next address SHALL appear the following cycle (1 spike/cycle at full throughput).
REQ-019 On the transfer of the last pending bit, next state SHALL be DONE.
REQ-020 In DONE, clear SHALL be 1 for exactly one cycle, then IDLE.
REQ-021 Latency: spikes_valid at edge N -> first out_valid after edge N; empty vector -> clear after edge N.
REQ-022 busy SHALL be 1 in SEND and DONE and 0 in IDLE.
REQ-023 spikes_valid when not IDLE SHALL be ignored (vector dropped); drop_count increments, saturating at 255.
REQ-024 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-025 RESET SHALL force IDLE, pending=0, out_valid=0, source_address=0, clear=0, busy=0, drop_count=0, immediately and asynchronously.
REQ-026 RESET mid-SEND SHALL discard all unsent spikes; no clear pulse SHALL follow.

Configuration
REQ-027 Macro SPIKE_DROP_COUNT_EN defined: drop_count SHALL be implemented per REQ-023.
REQ-028 Macro SPIKE_DROP_COUNT_EN undefined: drop_count SHALL be tied to 0 with no counter logic; all other behaviour SHALL be unchanged.

Structure
REQ-029 Package snn_noc_pkg SHALL hold ADDR_BITS, NUM_NEURONS defaults and the state enum type.
REQ-030 Sub-module spike_prio_enc SHALL hold the combinational lowest-set-bit encoder (index plus any-set flag).

Verification
REQ-031 base=0x100, spikes_in=10'b0000100101, out_ready=1 -> 0x100, 0x102, 0x105 on consecutive cycles, then a single clear pulse.
REQ-032 spikes_in=0 -> no out_valid; clear one cycle after spikes_valid; busy=1 for that DONE cycle only.
REQ-033 base=0xFFE, bits 0..3 set, out_ready toggling 1/0 -> 0xFFE, 0xFFF, 0x000, 0x001; address stable while out_ready=0.
REQ-034 spikes_valid pulsed 3 times during SEND -> those vectors are ignored, drop_count=3 (macro on) or 0 (macro off); 300 drops -> 255.
REQ-035 RESET asserted after 2 of 5 transfers -> outputs zero asynchronously; no further out_valid or clear; next spikes_valid works normally.
